// File: rtl/run_monitor.sv
// Observer for processor instruction tests: watches fetch PC and data-memory writes,
// folds writes into a signature and reports halt (jump-to-self) or cycle-budget timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; outputs hold reset/abort values
// S_RUN     | sampling pc/mem_* every edge, counting cycles, folding writes
// S_HALTED  | repeated PC seen HALT_REPEAT+1 times in a row; verdict frozen
// S_TIMEOUT | cycle budget exhausted without a halt; verdict frozen
module run_monitor #(
  parameter int          HALT_REPEAT    = 3,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter logic [31:0] SIG_INIT       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] expected_sig,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] cycles,
  output logic [31:0] signature,
  output logic [31:0] halt_pc
);

  localparam int              RW        = $clog2(HALT_REPEAT + 1);
  localparam logic [RW-1:0]   HALT_LAST = RW'(HALT_REPEAT - 1);
  localparam logic [RW-1:0]   HALT_MAX  = RW'(HALT_REPEAT);
  localparam logic [31:0]     TC_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   cycles_nxt, signature_nxt, halt_pc_nxt;
  logic [31:0]   prev_pc, prev_pc_nxt;
  logic [RW-1:0] repeat_cnt, repeat_cnt_nxt;
  logic          first_sample, first_sample_nxt;
  logic          same_pc, halt_hit, tc_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cycles       <= '0;
      signature    <= '0;
      halt_pc      <= '0;
      prev_pc      <= '0;
      repeat_cnt   <= '0;
      first_sample <= 1'b0;
    end else begin
      state        <= state_nxt;
      cycles       <= cycles_nxt;
      signature    <= signature_nxt;
      halt_pc      <= halt_pc_nxt;
      prev_pc      <= prev_pc_nxt;
      repeat_cnt   <= repeat_cnt_nxt;
      first_sample <= first_sample_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cycles_nxt       = cycles;
    signature_nxt    = signature;
    halt_pc_nxt      = halt_pc;
    prev_pc_nxt      = prev_pc;
    repeat_cnt_nxt   = repeat_cnt;
    first_sample_nxt = first_sample;

    same_pc  = (pc == prev_pc);
    halt_hit = (state == S_RUN) && !first_sample && same_pc && (repeat_cnt == HALT_LAST);
    tc_hit   = (cycles == TC_LAST);

    case (state)
      S_RUN: begin
        cycles_nxt  = cycles + 32'd1;
        prev_pc_nxt = pc;
        if (mem_we)
          signature_nxt = {signature[30:0], signature[31]} ^ mem_addr ^ mem_wdata;

        if (first_sample) begin
          repeat_cnt_nxt   = '0;
          first_sample_nxt = 1'b0;
        end else if (same_pc) begin
          repeat_cnt_nxt = (repeat_cnt == HALT_MAX) ? repeat_cnt : repeat_cnt + 1'b1;
        end else begin
          repeat_cnt_nxt = '0;
        end

        // halt outranks timeout when both land on the same edge
        if (halt_hit) begin
          state_nxt   = S_HALTED;
          halt_pc_nxt = pc;
        end else if (tc_hit) begin
          state_nxt = S_TIMEOUT;
        end
      end

      default: begin
        if (start) begin
          state_nxt        = S_RUN;
          signature_nxt    = SIG_INIT;
          cycles_nxt       = '0;
          repeat_cnt_nxt   = '0;
          first_sample_nxt = 1'b1;
        end
      end
    endcase
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_HALTED) || (state == S_TIMEOUT);
  assign timeout = (state == S_TIMEOUT);
  assign pass    = (state == S_HALTED) && (signature == expected_sig);

endmodule
